fetch_stage: RTL
================

// Module: fetch_stage
//
// PURPOSE
//  Instruction-fetch stage, directly upstream of decode. Holds the PC and issues
//  one read at a time to instruction memory over a mem_read_req_t/mem_read_rsp_t
//  handshake. Produces the if_id_t pipeline register that decode consumes.
//  Applies backpressure from decode, taken-branch/jump redirects from execute,
//  and fetch faults.
//
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC fetched first after reset release
//  PC_STEP    4               PC increment per sequential instruction (bytes)
//
// PORTS
//  clk             in   1                clock
//  rst             in   1                reset, asynchronous, active-high
//  en              in   1                stage enable; low = no new request, if_id frozen
//  decode_rdy      in   1                decode can take if_id this cycle
//  redirect_valid  in   1                execute redirects fetch (taken branch/jump)
//  redirect_pc     in   32               redirect target; bits [1:0] ignored (forced 0)
//  imem_read_rsp   in   mem_read_rsp_t   {data, done, valid} from instruction memory
//  imem_read_req   out  mem_read_req_t   {addr, mask, en} to instruction memory
//  rdy             out  1                a valid instruction is delivered into if_id this cycle
//  fault           out  1                fetch fault latched; fetching halted
//  if_id           out  if_id_t          {inst, pc, valid} register to decode
//
// BEHAVIOUR
//  - Reset (async): state=IDLE; pc=RESET_PC; req_addr=RESET_PC; hold buffer empty;
//    squash=0; fault=0; if_id all zero (valid=0). imem_read_req.en=0, rdy=0.
//  - Request rules:
//    - One request outstanding at most.
//    - imem_read_req.en=1 only in REQ and SQUASH.
//    - addr=req_addr and mask=4'b1111 are held stable until a cycle with rsp.done=1.
//    - A request is never withdrawn, even when en=0 or on a redirect.
//  - advance = en && decode_rdy. if_id updates only when advance=1:
//    - loaded with {inst, pc, 1} when an instruction is delivered;
//    - otherwise valid<=0 (bubble).
//    - When advance=0, if_id holds.
//  - States:
//    - IDLE: no request. Goes to REQ (req_addr=pc) when en=1.
//    - REQ: request at req_addr.
//      - On done && valid, delivery goes direct to if_id if advance:
//        pc+=PC_STEP; the next request issues the following cycle at the new pc
//        (REQ stays; IDLE if en=0).
//      - On done && valid without advance: data goes to the hold buffer, go HOLD.
//      - On done && !valid: go FAULT.
//    - HOLD: en=0 on the request port. When advance: if_id<=hold, pc+=PC_STEP,
//      then go REQ (IDLE if en=0).
//    - SQUASH: request still outstanding but its result is unwanted. On done
//      (valid or not), discard and go REQ at pc.
//    - FAULT: fault=1, no requests, if_id.valid<=0 on advance. Exit only by
//      redirect or rst.
//  - Redirect (redirect_valid=1) takes priority over all other events that cycle:
//    - pc<=redirect_pc, hold buffer emptied, fault<=0.
//    - if_id.valid<=0 regardless of advance.
//    - If in REQ/SQUASH and done=0 this cycle: go SQUASH.
//    - Otherwise (incl. done=1 the same cycle): the response is dropped; go REQ
//      at redirect_pc (IDLE if en=0).
//  - Latency and throughput:
//    - With a zero-wait memory (done the same cycle as en), an instruction is
//      in if_id 1 cycle after its request.
//    - Throughput is 1 instruction per cycle.
//    - With N-cycle memory, throughput is 1 per N cycles.
//  - rdy=1 exactly in cycles where if_id is loaded with valid=1 at the next edge.
//  - PC wraps modulo 2^32 (0xFFFF_FFFC + 4 -> 0x0).
//  - rst mid-request: the outstanding response is abandoned; memory must accept a
//    dropped request.
//
// STRUCTURE
//  - The shared package gets fetch_state_t (IDLE, REQ, HOLD, SQUASH, FAULT) and
//    PC_WIDTH. It reuses the existing if_id_t, mem_read_req_t and mem_read_rsp_t.
//  - Single flat module; no sub-modules. The hold buffer is one 32-bit register
//    plus a state bit.
//
// TESTING
//  1. rst release, en=1, decode_rdy=1, zero-wait mem -> if_id.pc = 0x0, 0x4, 0x8
//     on consecutive cycles; inst matches mem; rdy=1 each cycle.
//  2. Mem latency 3 -> imem_read_req.addr stable for 3 cycles; one valid if_id per
//     3 cycles; bubbles (valid=0) in between.
//  3. decode_rdy=0 for 2 cycles when the 0x8 response arrives -> HOLD, req.en=0,
//     if_id unchanged. On decode_rdy=1, inst@0x8 is delivered once, then the next
//     request is at 0xC.
//  4. Redirect to 0x100 while 0x8 is outstanding (done 2 cycles later) -> if_id.valid=0
//     next cycle; 0x8 data is never delivered; the next request is at 0x100.
//  5. rsp.valid=0 for 0xC -> fault=1, req.en=0 thereafter. Redirect to 0x40 ->
//     fault=0; first delivered pc=0x40.
//  6. rst asserted mid-request with a 2-cycle memory -> outputs zero immediately
//     (async); after release the first request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared types for the instruction-fetch stage and its neighbours:
//   fetch_state_t   - fetch controller states
//   PC_WIDTH        - program-counter width in bits
//   mem_read_req_t  - {addr, mask, en} read request to instruction memory
//   mem_read_rsp_t  - {data, done, valid} read response from instruction memory
//   if_id_t         - {inst, pc, valid} fetch-to-decode pipeline register
// ----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int PC_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_HOLD   = 3'd2,
    S_SQUASH = 3'd3,
    S_FAULT  = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic        en;
  } mem_read_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        done;
    logic        valid;
  } mem_read_rsp_t;

  typedef struct packed {
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] pc;
    logic                valid;
  } if_id_t;

  // Instructions are word aligned: the two low address bits are forced to zero.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] a);
    return {a[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage feeding decode. Holds the PC, keeps at most one read
// outstanding to instruction memory and produces the if_id pipeline register.
// Handles decode backpressure (hold buffer), execute redirects (squash of an
// in-flight read) and fetch faults (halt until redirect).
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   en              stage enable; low = no new request, if_id frozen
//   decode_rdy      decode can take if_id this cycle
//   redirect_valid  redirect from execute, redirect_pc = target (bits [1:0] ignored)
//   imem_read_rsp   {data, done, valid} from instruction memory
//   imem_read_req   {addr, mask, en} to instruction memory
//   rdy             a valid instruction enters if_id at the next edge
//   fault           fetch fault latched, fetching halted
//   if_id           {inst, pc, valid} register to decode
// ----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned         PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                decode_rdy,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  mem_read_rsp_t       imem_read_rsp,
  output mem_read_req_t       imem_read_req,
  output logic                rdy,
  output logic                fault,
  output if_id_t              if_id
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [31:0]         hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                fault_q, fault_d;
  if_id_t              if_id_q, if_id_d;

  logic                advance_s;
  logic                req_busy_s;
  logic                rsp_ok_s;
  logic                rsp_err_s;
  logic                rdy_s;
  logic [PC_WIDTH-1:0] pc_inc_s;
  logic [PC_WIDTH-1:0] redirect_tgt_s;
  logic                redirect_pc_unused_s;

  assign advance_s      = en & decode_rdy;
  assign req_busy_s     = (state_q == S_REQ) || (state_q == S_SQUASH);
  assign rsp_ok_s       = imem_read_rsp.done & imem_read_rsp.valid;
  assign rsp_err_s      = imem_read_rsp.done & ~imem_read_rsp.valid;
  // Wraps modulo 2^PC_WIDTH by construction.
  assign pc_inc_s       = pc_q + STEP;
  assign redirect_tgt_s = align_pc(redirect_pc);
  // Low target bits carry no information; they are dropped by align_pc.
  assign redirect_pc_unused_s = ^redirect_pc[1:0];

  // Next-state, datapath and rdy computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    fault_d    = fault_q;
    if_id_d    = if_id_q;
    rdy_s      = 1'b0;

    if (redirect_valid) begin
      // Redirect wins over every other event this cycle.
      pc_d          = redirect_tgt_s;
      hold_vld_d    = 1'b0;
      fault_d       = 1'b0;
      if_id_d.valid = 1'b0;
      if (req_busy_s && !imem_read_rsp.done) begin
        // The read cannot be withdrawn: keep it on the port and drop its data later.
        state_d = S_SQUASH;
      end else begin
        req_addr_d = redirect_tgt_s;
        state_d    = en ? S_REQ : S_IDLE;
      end
    end else begin
      // Bubble by default whenever decode advances; deliveries below override it.
      if (advance_s) begin
        if_id_d.valid = 1'b0;
      end else begin
        if_id_d.valid = if_id_q.valid;
      end

      case (state_q)
        S_IDLE: begin
          if (en) begin
            req_addr_d = pc_q;
            state_d    = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_REQ: begin
          if (rsp_ok_s) begin
            if (advance_s) begin
              if_id_d    = '{inst: imem_read_rsp.data, pc: pc_q, valid: 1'b1};
              rdy_s      = 1'b1;
              pc_d       = pc_inc_s;
              req_addr_d = pc_inc_s;
              state_d    = S_REQ;
            end else begin
              hold_d     = imem_read_rsp.data;
              hold_vld_d = 1'b1;
              state_d    = S_HOLD;
            end
          end else if (rsp_err_s) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            state_d = S_REQ;
          end
        end

        S_HOLD: begin
          if (advance_s && hold_vld_q) begin
            if_id_d    = '{inst: hold_q, pc: pc_q, valid: 1'b1};
            rdy_s      = 1'b1;
            hold_vld_d = 1'b0;
            pc_d       = pc_inc_s;
            req_addr_d = pc_inc_s;
            state_d    = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end

        S_SQUASH: begin
          if (imem_read_rsp.done) begin
            // Stale response is discarded; refetch from the redirected pc.
            req_addr_d = pc_q;
            state_d    = en ? S_REQ : S_IDLE;
          end else begin
            state_d = S_SQUASH;
          end
        end

        S_FAULT: begin
          state_d = S_FAULT;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_q     <= 32'h0000_0000;
      hold_vld_q <= 1'b0;
      fault_q    <= 1'b0;
      if_id_q    <= '{inst: 32'h0000_0000, pc: {PC_WIDTH{1'b0}}, valid: 1'b0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      fault_q    <= fault_d;
      if_id_q    <= if_id_d;
    end
  end

  // Request port driven straight from registered state.
  always_comb begin
    imem_read_req = '{addr: req_addr_q, mask: 4'b1111, en: req_busy_s};
  end

  assign rdy   = rdy_s;
  assign fault = fault_q;
  assign if_id = if_id_q;

endmodule
